// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pads and the debounced consumers.
// master drives the raw buttons, slave is the conditioner.
interface btn_debounce_if #(
  parameter int N_BTN = 12
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, any_press
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, any_press
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button synchroniser, debouncer and edge detector.
// One lane instance per button; lanes are fully independent.
module btn_debounce_lane #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q,   rel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    // Counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
        rel_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
endmodule

module btn_debounce #(
  parameter int N_BTN     = 12,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_debounce_lane #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.btn_in[g]),
      .level_o (level[g]),
      .press_o (press[g]),
      .rel_o   (rel[g])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  // Pulses are already registered, so the OR lines up with them.
  assign bus.any_press   = |press;
endmodule

// File: tb/tb_btn_debounce.sv
// Directed scenarios followed by random button activity, all checked
// against a window-based reference model of the debounce rule.
module tb_btn_debounce;
  localparam int N  = 12;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  btn_debounce_if #(.N_BTN(N)) bus ();

  btn_debounce #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last DB synchronised samples
  // (taken since the previous flip or reset) all oppose it.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] s2_hist[$];
  int           since_flip[N];
  logic [N-1:0] m_level   = '0;
  logic [N-1:0] m_press   = '0;
  logic [N-1:0] m_release = '0;

  always @(posedge clk) begin
    logic [N-1:0] s2;
    bit           all_opp;
    if (rst) begin
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      s2_hist.delete();
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < N; i++) since_flip[i] = 0;
    end else begin
      s2 = raw_q[raw_q.size() - 2];
      raw_q.push_back(bus.btn_in);
      s2_hist.push_back(s2);
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < N; i++) begin
        since_flip[i]++;
        if (since_flip[i] >= DB) begin
          all_opp = 1'b1;
          for (int j = 0; j < DB; j++)
            if (s2_hist[s2_hist.size() - 1 - j][i] == m_level[i]) all_opp = 1'b0;
          if (all_opp) begin
            m_level[i]    = ~m_level[i];
            m_press[i]    = m_level[i];
            m_release[i]  = ~m_level[i];
            since_flip[i] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_model();
    chk("level",   32'(bus.btn_level),   32'(m_level));
    chk("press",   32'(bus.btn_press),   32'(m_press));
    chk("release", 32'(bus.btn_release), 32'(m_release));
    chk("any",     32'(bus.any_press),   32'(|m_press));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      chk_model();
    end
  endtask

  int any_cnt;

  initial begin
    bus.btn_in = '0;

    // Reset, then idle
    step(3);
    chk("rst_level", 32'(bus.btn_level), 32'h0);
    chk("rst_press", 32'(bus.btn_press | bus.btn_release), 32'h0);
    rst = 1'b0;
    step(20);
    chk("idle_level", 32'(bus.btn_level), 32'h0);

    // Clean press: level and pulse at the 6th edge after the change
    bus.btn_in[0] = 1'b1;
    step(5);
    chk("press_early", 32'(bus.btn_level[0]), 32'h0);
    step(1);
    chk("press_level", 32'(bus.btn_level[0]), 32'h1);
    chk("press_pulse", 32'(bus.btn_press),    32'h001);
    step(1);
    chk("press_end",   32'(bus.btn_press[0]), 32'h0);
    step(3);

    // Release
    bus.btn_in[0] = 1'b0;
    step(5);
    chk("rel_early", 32'(bus.btn_release[0]), 32'h0);
    step(1);
    chk("rel_pulse", 32'(bus.btn_release),    32'h001);
    chk("rel_level", 32'(bus.btn_level[0]),   32'h0);
    step(1);
    chk("rel_end",   32'(bus.btn_release[0]), 32'h0);
    step(5);

    // Bounce shorter than the stability window
    for (int t = 0; t < 4; t++) begin
      bus.btn_in[1] = (t % 2 == 0);
      repeat (2) begin
        step(1);
        chk("bounce_lvl", 32'(bus.btn_level[1]), 32'h0);
        chk("bounce_pls", 32'(bus.btn_press[1] | bus.btn_release[1]), 32'h0);
      end
    end
    bus.btn_in[1] = 1'b0;
    repeat (10) begin
      step(1);
      chk("bounce_lvl", 32'(bus.btn_level[1]), 32'h0);
      chk("bounce_pls", 32'(bus.btn_press[1] | bus.btn_release[1]), 32'h0);
    end

    // Simultaneous presses
    bus.btn_in[3]  = 1'b1;
    bus.btn_in[11] = 1'b1;
    any_cnt = 0;
    repeat (10) begin
      step(1);
      if (bus.any_press) any_cnt++;
      if (bus.btn_press != '0) chk("sim_press", 32'(bus.btn_press), 32'h808);
    end
    chk("sim_any_once", 32'(any_cnt), 32'h1);
    chk("sim_level", 32'(bus.btn_level), 32'h808);
    bus.btn_in[3]  = 1'b0;
    bus.btn_in[11] = 1'b0;
    step(10);

    // Reset while button 2 is mid-count, still held afterwards
    bus.btn_in[2] = 1'b1;
    step(4);
    rst = 1'b1;
    step(2);
    chk("mid_rst_out", 32'(bus.btn_level | bus.btn_press), 32'h0);
    rst = 1'b0;
    step(5);
    chk("mid_rst_early", 32'(bus.btn_press[2]), 32'h0);
    step(1);
    chk("mid_rst_press", 32'(bus.btn_press), 32'h004);
    step(1);
    chk("mid_rst_end", 32'(bus.btn_press[2]), 32'h0);
    step(20);
    chk("held_no_repeat", 32'(bus.btn_level[2]), 32'h1);

    // Random activity with occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) bus.btn_in[i] = ~bus.btn_in[i];
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
